simf_wb_arbiter: RTL and testbench

SIMF_WB_ARBITER -- requirements
Module: simf_wb_arbiter

---
 rtl/simf_wb_arbiter.sv | 118 +++++++++++
 tb/tb_simf_wb_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/simf_wb_arbiter.sv
// simf_wb_arbiter: arbitrates the single VGPR write port between the LSU and
// four SIMF result queues. Grants are registered single-cycle pulses issued one
// clock after the requests are sampled. The LSU has priority over the SIMF
// queues, and the SIMF queues share their slot round-robin.
// Optional feature: define SIMF_WB_ARB_STARVE_EN to enable the starvation
// guard. After STARVE_LIMIT consecutive LSU grants taken while a SIMF result
// was waiting, the next slot goes to SIMF.
module simf_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lsu_wr_req,
    input  logic [3:0] simf_queue_entry_valid,
    output logic [3:0] simf_queue_entry_serviced,
    output logic       lsu_wr_grant,
    output logic [1:0] arb_grant_id,
    output logic       arb_idle
);

    logic [3:0] serviced_q, serviced_d;
    logic       lsu_grant_q, lsu_grant_d;
    logic [1:0] grant_id_q, grant_id_d;
    logic       idle_q, idle_d;
    logic [1:0] ptr_q, ptr_d;

    logic [3:0] eligible;
    logic       simf_pending;
    logic [1:0] rr_pick;
    logic       starve_force;
    logic       simf_win;

    // The unit being serviced this cycle still shows valid, so it is excluded
    // from the arbitration sampled at this edge.
    assign eligible     = simf_queue_entry_valid & ~serviced_q;
    assign simf_pending = |eligible;

`ifdef SIMF_WB_ARB_STARVE_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign starve_force = (starve_cnt_q == 4'(STARVE_LIMIT));

    // Count LSU wins that kept a pending SIMF result waiting. Any SIMF grant or
    // any cycle with no SIMF pending starts the count again.
    always_comb begin
        starve_cnt_d = '0;
        if (!simf_win && lsu_wr_req && simf_pending) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic [3:0] unused_starve_limit;

    assign unused_starve_limit = 4'(STARVE_LIMIT);
    assign starve_force        = 1'b0;
`endif

    // Search upward from the pointer, wrapping modulo 4. The descending loop
    // lets the nearest eligible offset take the last assignment.
    always_comb begin
        rr_pick = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (eligible[ptr_q + 2'(k)]) begin
                rr_pick = ptr_q + 2'(k);
            end
        end
    end

    assign simf_win = simf_pending && (!lsu_wr_req || starve_force);

    // Grant selection. Only a SIMF grant moves the round-robin pointer.
    always_comb begin
        serviced_d  = '0;
        lsu_grant_d = 1'b0;
        grant_id_d  = '0;
        ptr_d       = ptr_q;
        if (simf_win) begin
            serviced_d = 4'b0001 << rr_pick;
            grant_id_d = rr_pick;
            ptr_d      = rr_pick + 2'd1;
        end else if (lsu_wr_req) begin
            lsu_grant_d = 1'b1;
        end
        idle_d = !(simf_win || lsu_wr_req);
    end

    // Registered grant outputs and pointer. Reset drops any grant in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            serviced_q  <= '0;
            lsu_grant_q <= 1'b0;
            grant_id_q  <= '0;
            idle_q      <= 1'b1;
            ptr_q       <= '0;
        end else begin
            serviced_q  <= serviced_d;
            lsu_grant_q <= lsu_grant_d;
            grant_id_q  <= grant_id_d;
            idle_q      <= idle_d;
            ptr_q       <= ptr_d;
        end
    end

    assign simf_queue_entry_serviced = serviced_q;
    assign lsu_wr_grant              = lsu_grant_q;
    assign arb_grant_id              = grant_id_q;
    assign arb_idle                  = idle_q;

endmodule

// File: tb/tb_simf_wb_arbiter.sv
// tb_simf_wb_arbiter: self-checking bench for simf_wb_arbiter. It runs the
// directed scenarios with literal expectations, then randomized traffic that a
// behavioural arbitration model checks on every cycle.
module tb_simf_wb_arbiter;

    localparam int LIMIT = 8;

    logic       clk;
    logic       rst;
    logic       lsu_wr_req;
    logic [3:0] simf_valid;
    logic [3:0] serviced;
    logic       lsu_grant;
    logic [1:0] grant_id;
    logic       idle;

    int checks = 0;
    int errors = 0;
    bit model_on = 0;

    // Behavioural model state: the outputs expected for the current cycle
    int         m_ptr = 0;
    int         m_cnt = 0;
    int         m_id = 0;
    logic [3:0] m_serv = '0;
    logic       m_lsu = 1'b0;
    int         pick;
    int         idx;
    bit         force_simf;

    simf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .lsu_wr_req                (lsu_wr_req),
        .simf_queue_entry_valid    (simf_valid),
        .simf_queue_entry_serviced (serviced),
        .lsu_wr_grant              (lsu_grant),
        .arb_grant_id              (grant_id),
        .arb_idle                  (idle)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arbitration. A unit shown as serviced this cycle cannot be
    // picked again. The search starts at the pointer and wraps modulo 4.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ptr  = 0;
            m_cnt  = 0;
            m_id   = 0;
            m_serv = '0;
            m_lsu  = 1'b0;
        end else begin
            pick = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (pick < 0 && simf_valid[idx] && !m_serv[idx]) pick = idx;
            end
`ifdef SIMF_WB_ARB_STARVE_EN
            force_simf = (m_cnt == LIMIT);
`else
            force_simf = 0;
`endif
            m_serv = '0;
            m_lsu  = 1'b0;
            m_id   = 0;
            if (pick >= 0 && (!lsu_wr_req || force_simf)) begin
                m_serv[pick] = 1'b1;
                m_id  = pick;
                m_ptr = (pick + 1) % 4;
                m_cnt = 0;
            end else if (lsu_wr_req) begin
                m_lsu = 1'b1;
                m_cnt = (pick >= 0) ? m_cnt + 1 : 0;
            end else begin
                m_cnt = 0;
            end
        end
    end

    // Compare the DUT against the model every cycle, away from the sampling edge
    always @(negedge clk) begin
        if (model_on) begin
            checks++;
            if (serviced !== m_serv || lsu_grant !== m_lsu ||
                grant_id !== 2'(m_id) || idle !== !(m_lsu || (|m_serv))) begin
                errors++;
                $display("[TB] FAIL model_cmp t=%0t got serviced=%b lsu=%b id=%0d idle=%b expected serviced=%b lsu=%b id=%0d idle=%b",
                         $time, serviced, lsu_grant, grant_id, idle,
                         m_serv, m_lsu, m_id, !(m_lsu || (|m_serv)));
            end
        end
    end

    task automatic applyStimulus(input logic lsu, input logic [3:0] valid);
        lsu_wr_req = lsu;
        simf_valid = valid;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] e_serv,
                               input logic e_lsu, input logic [1:0] e_id,
                               input logic e_idle);
        checks++;
        if (serviced !== e_serv || lsu_grant !== e_lsu ||
            grant_id !== e_id || idle !== e_idle) begin
            errors++;
            $display("[TB] FAIL %s got serviced=%b lsu=%b id=%0d idle=%b expected serviced=%b lsu=%b id=%0d idle=%b",
                     name, serviced, lsu_grant, grant_id, idle,
                     e_serv, e_lsu, e_id, e_idle);
        end
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [3:0] next_valid;

        rst = 1'b0;
        applyStimulus(1'b0, 4'b0000);
        repeat (2) @(negedge clk);
        checkOutput("reset_state", 4'b0000, 1'b0, 2'd0, 1'b1);
        #1 rst = 1'b1;
        model_on = 1;

        // Hold all four queues valid: the grants rotate 0,1,2,3,0,1,2.
        @(negedge clk);
        #1 applyStimulus(1'b0, 4'b1111);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rr_seq%0d", i), 4'(1 << (i % 4)), 1'b0,
                        2'(i % 4), 1'b0);
        end

        // Drop reset while unit 2 is being serviced, then restart from pointer 0.
        #1 rst = 1'b0;
        #1 checkOutput("async_reset", 4'b0000, 1'b0, 2'd0, 1'b1);
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_first", 4'b0001, 1'b0, 2'd0, 1'b0);

        // A single request that drops on seeing serviced is granted once.
        #1 rst = 1'b0;
        applyStimulus(1'b0, 4'b0000);
        @(negedge clk);
        #1 rst = 1'b1;
        applyStimulus(1'b0, 4'b0100);
        @(negedge clk);
        checkOutput("single_pulse", 4'b0100, 1'b0, 2'd2, 1'b0);
        #1 applyStimulus(1'b0, 4'b0000);
        @(negedge clk);
        checkOutput("no_repeat", 4'b0000, 1'b0, 2'd0, 1'b1);
        @(negedge clk);
        checkOutput("idle_after", 4'b0000, 1'b0, 2'd0, 1'b1);

        // The LSU wins first, and the SIMF unit is granted once the LSU lets go.
        #1 applyStimulus(1'b1, 4'b0010);
        @(negedge clk);
        checkOutput("lsu_wins", 4'b0000, 1'b1, 2'd0, 1'b0);
        #1 applyStimulus(1'b0, 4'b0010);
        @(negedge clk);
        checkOutput("simf_after_lsu", 4'b0010, 1'b0, 2'd1, 1'b0);

        // The LSU requests every cycle while unit 0 stays valid.
        #1 applyStimulus(1'b1, 4'b0001);
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            checkOutput($sformatf("lsu_streak%0d", i), 4'b0000, 1'b1, 2'd0, 1'b0);
        end
        @(negedge clk);
`ifdef SIMF_WB_ARB_STARVE_EN
        checkOutput("starve_forced", 4'b0001, 1'b0, 2'd0, 1'b0);
`else
        checkOutput("strict_lsu", 4'b0000, 1'b1, 2'd0, 1'b0);
`endif
        @(negedge clk);
        checkOutput("lsu_resumes", 4'b0000, 1'b1, 2'd0, 1'b0);

        // Randomized traffic. A serviced unit usually drops its valid, and
        // valids sometimes drop without ever being granted.
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            #1;
            next_valid = simf_valid;
            for (int b = 0; b < 4; b++) begin
                if (m_serv[b]) begin
                    if ($urandom_range(0, 3) != 0) next_valid[b] = 1'b0;
                end else if (!next_valid[b]) begin
                    if ($urandom_range(0, 2) == 0) next_valid[b] = 1'b1;
                end else if ($urandom_range(0, 15) == 0) begin
                    next_valid[b] = 1'b0;
                end
            end
            if (cyc < 300) applyStimulus(($urandom_range(0, 3) != 0), next_valid);
            else applyStimulus(($urandom_range(0, 9) != 0), next_valid);
            if (cyc == 400) rst = 1'b0;
            if (cyc == 402) rst = 1'b1;
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
